set_scan_engine: RTL



---
 rtl/set_scan_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/set_scan_engine.sv
// Counts grid points satisfying a set expression over three circles,
// scanning LANES points per cycle under a simple IDLE/SCAN/DONE job FSM.
module set_scan_engine #(
   parameter int GRID    = 8,
   parameter int COORD_W = 4,
   parameter int LANES   = 8,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [6*COORD_W-1:0]   central,
   input  logic [3*COORD_W-1:0]   radius,
   input  logic [2:0]             mode,
   output logic                   busy,
   output logic                   valid,
   output logic [CNT_W-1:0]       candidate
);

   localparam int NPTS  = GRID * GRID;
   localparam int IDX_W = $clog2(NPTS + 1);
   localparam int D_W   = COORD_W + 2;
   localparam int S_W   = 2 * COORD_W + 4;
   localparam int PC_W  = $clog2(LANES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - LANES);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [CNT_W-1:0]       r_acc;
   logic [6*COORD_W-1:0]   r_central;
   logic [3*COORD_W-1:0]   r_radius;
   logic [2:0]             r_modeSel;

   logic [COORD_W-1:0]     w_cx [3];
   logic [COORD_W-1:0]     w_cy [3];
   logic [COORD_W-1:0]     w_rad [3];
   logic [LANES-1:0]       w_hit;
   logic [PC_W-1:0]        w_batchCount;

   // Exact squared distance; the centre may lie off-grid, so keep full width.
   function automatic logic inCircle(
      input logic [D_W-1:0]     px,
      input logic [D_W-1:0]     py,
      input logic [COORD_W-1:0] cx,
      input logic [COORD_W-1:0] cy,
      input logic [COORD_W-1:0] rad
   );
      logic signed [D_W-1:0] dx;
      logic signed [D_W-1:0] dy;
      logic signed [S_W-1:0] dxe;
      logic signed [S_W-1:0] dye;
      logic [S_W-1:0]        distSq;
      logic [S_W-1:0]        radSq;
      dx     = $signed(px) - $signed({2'b00, cx});
      dy     = $signed(py) - $signed({2'b00, cy});
      dxe    = S_W'(dx);
      dye    = S_W'(dy);
      distSq = $unsigned(dxe * dxe + dye * dye);
      radSq  = S_W'(rad) * S_W'(rad);
      return distSq <= radSq;
   endfunction

   function automatic logic setSelect(
      input logic [2:0] sel,
      input logic       a,
      input logic       b,
      input logic       c
   );
      logic [1:0] n;
      n = {1'b0, a} + {1'b0, b} + {1'b0, c};
      case (sel)
         3'd0:    return a;
         3'd1:    return a & b;
         3'd2:    return a ^ b;
         3'd3:    return n == 2'd2;
         3'd4:    return a | b | c;
         3'd5:    return a & b & c;
         3'd6:    return n >= 2'd2;
         default: return 1'b0;
      endcase
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_field
      assign w_cx[k]  = r_central[(6-2*k)*COORD_W-1 -: COORD_W];
      assign w_cy[k]  = r_central[(5-2*k)*COORD_W-1 -: COORD_W];
      assign w_rad[k] = r_radius[(3-k)*COORD_W-1 -: COORD_W];
   end

   // Row-major mapping of the lane's linear index onto 1-based coordinates.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [IDX_W-1:0] w_pointIdx;
      logic [D_W-1:0]   w_x;
      logic [D_W-1:0]   w_y;
      logic             w_a;
      logic             w_b;
      logic             w_c;
      assign w_pointIdx = r_idx + IDX_W'(g);
      assign w_x = D_W'(w_pointIdx % IDX_W'(GRID)) + D_W'(1);
      assign w_y = D_W'(w_pointIdx / IDX_W'(GRID)) + D_W'(1);
      assign w_a = inCircle(w_x, w_y, w_cx[0], w_cy[0], w_rad[0]);
      assign w_b = inCircle(w_x, w_y, w_cx[1], w_cy[1], w_rad[1]);
      assign w_c = inCircle(w_x, w_y, w_cx[2], w_cy[2], w_rad[2]);
      assign w_hit[g] = setSelect(r_modeSel, w_a, w_b, w_c);
   end

   always_comb begin
      w_batchCount = '0;
      for (int l = 0; l < LANES; l++) begin
         w_batchCount = w_batchCount + PC_W'(w_hit[l]);
      end
   end

   // Outputs are registered so valid and candidate appear together on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_acc     <= '0;
         r_central <= '0;
         r_radius  <= '0;
         r_modeSel <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         candidate <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               valid <= 1'b0;
               if (en) begin
                  r_central <= central;
                  r_radius  <= radius;
                  r_modeSel <= mode;
                  r_acc     <= '0;
                  r_idx     <= '0;
                  busy      <= 1'b1;
                  r_state   <= SCAN;
               end
            end
            SCAN: begin
               r_acc <= r_acc + CNT_W'(w_batchCount);
               r_idx <= r_idx + IDX_W'(LANES);
               if (r_idx == LAST_IDX) begin
                  candidate <= r_acc + CNT_W'(w_batchCount);
                  valid     <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               valid   <= 1'b0;
               busy    <= 1'b0;
               r_idx   <= '0;
               r_state <= IDLE;
            end
            default: begin
               valid   <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
